// File: rtl/w0rm_alu_writeback.sv
// w0rm_alu_writeback: in-order completion queue and register-file writeback
// stage behind the W0RM ALU execution units. Units emit single-cycle result
// pulses. Each pulse lands in the oldest pending queue entry issued to that
// unit. Entries retire in issue order onto a valid/ready write port, and the
// architectural flags register is kept here.
// Optional build macro: W0RM_ALU_WB_ORPHAN_CHECK_EN adds a sticky err_orphan
// output that flags unit results with no matching pending entry.
module w0rm_alu_writeback #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_UNITS      = 4,
  parameter int UNIT_ID_WIDTH  = 2,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DEPTH          = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            issue_valid,
  output logic                            issue_ready,
  input  logic [UNIT_ID_WIDTH-1:0]        issue_unit,
  input  logic [REG_ADDR_WIDTH-1:0]       issue_dest,
  input  logic                            issue_flags_we,
  input  logic [NUM_UNITS-1:0]            unit_result_valid,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result,
  input  logic [NUM_UNITS*4-1:0]          unit_result_flags,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [DATA_WIDTH-1:0]           wb_data,
  output logic [REG_ADDR_WIDTH-1:0]       wb_dest,
  output logic [3:0]                      flags_out,
`ifdef W0RM_ALU_WB_ORPHAN_CHECK_EN
  output logic                            pending,
  output logic                            err_orphan
`else
  output logic                            pending
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Queue storage
  logic [UNIT_ID_WIDTH-1:0]  ent_unit  [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] ent_dest  [DEPTH];
  logic [DATA_WIDTH-1:0]     ent_data  [DEPTH];
  logic [3:0]                ent_flags [DEPTH];
  logic [DEPTH-1:0]          ent_fwe;
  logic [DEPTH-1:0]          ent_done;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [DEPTH-1:0]      ent_live;
  logic [NUM_UNITS-1:0]  cap_hit;
  logic [PTR_W-1:0]      cap_idx [NUM_UNITS];
  logic [PTR_W-1:0]      scan_idx;
  logic [PTR_W-1:0]      off;

  logic                  head_live;
  logic                  head_bypass;
  logic [DATA_WIDTH-1:0] byp_data;
  logic [3:0]            byp_flags;
  logic                  head_ready;
  logic                  retire;
  logic                  issue_fire;
  logic [DATA_WIDTH-1:0] ret_data;
  logic [3:0]            ret_flags;

  assign issue_ready = (count != CNT_W'(DEPTH));
  assign issue_fire  = issue_valid && issue_ready;
  assign pending     = (count != '0) || wb_valid;

  // Mark entries between head and head+count as occupied (registered count only,
  // so entries allocated this cycle are never capture targets).
  always_comb begin
    ent_live = '0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = PTR_W'(i) - head;
      ent_live[i] = ({1'b0, off} < count);
    end
  end

  // For every pulsing unit, locate the oldest occupied, not-yet-done entry
  // that was issued to it; scanning young-to-old leaves the oldest match.
  always_comb begin
    cap_hit     = '0;
    scan_idx    = '0;
    head_bypass = 1'b0;
    byp_data    = '0;
    byp_flags   = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      cap_idx[u] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        scan_idx = head + PTR_W'(k);
        if (unit_result_valid[u] && ent_live[scan_idx] && !ent_done[scan_idx] &&
            (ent_unit[scan_idx] == UNIT_ID_WIDTH'(u))) begin
          cap_hit[u] = 1'b1;
          cap_idx[u] = scan_idx;
        end
      end
      // A result aimed at the head can retire on the same edge it arrives.
      if (cap_hit[u] && (cap_idx[u] == head)) begin
        head_bypass = 1'b1;
        byp_data    = unit_result[u*DATA_WIDTH +: DATA_WIDTH];
        byp_flags   = unit_result_flags[u*4 +: 4];
      end
    end
  end

  // Retire decision and the value presented from the head entry.
  always_comb begin
    head_live  = (count != '0);
    head_ready = head_live && (ent_done[head] || head_bypass);
    retire     = head_ready && (!wb_valid || wb_ready);
    ret_data   = ent_done[head] ? ent_data[head]  : byp_data;
    ret_flags  = ent_done[head] ? ent_flags[head] : byp_flags;
  end

  // Control state: pointers, count, done bits, writeback port and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_done  <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_dest   <= '0;
      flags_out <= 4'h0;
    end else begin
      if (issue_fire) begin
        ent_done[tail] <= 1'b0;
        tail           <= tail + 1'b1;
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (cap_hit[u]) ent_done[cap_idx[u]] <= 1'b1;
      end
      if (retire) begin
        wb_valid <= 1'b1;
        wb_data  <= ret_data;
        wb_dest  <= ent_dest[head];
        head     <= head + 1'b1;
        if (ent_fwe[head]) flags_out <= ret_flags;
      end else if (wb_valid && wb_ready) begin
        wb_valid <= 1'b0;
      end
      count <= count + CNT_W'(issue_fire) - CNT_W'(retire);
    end
  end

  // Entry payload: issue fields at allocation, result fields at capture.
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      ent_unit[tail] <= issue_unit;
      ent_dest[tail] <= issue_dest;
      ent_fwe[tail]  <= issue_flags_we;
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (cap_hit[u]) begin
        ent_data[cap_idx[u]]  <= unit_result[u*DATA_WIDTH +: DATA_WIDTH];
        ent_flags[cap_idx[u]] <= unit_result_flags[u*4 +: 4];
      end
    end
  end

`ifdef W0RM_ALU_WB_ORPHAN_CHECK_EN
  // Sticky orphan flag: any pulse that found no pending entry of its unit.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_orphan <= 1'b0;
    end else if (|(unit_result_valid & ~cap_hit)) begin
      err_orphan <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/w0rm_alu_writeback.md
Name: w0rm_alu_writeback

Overview:
- In-order completion and writeback stage directly downstream of the W0RM ALU execution units (add/sub, logic, shift, extend, ...).
- Each unit emits a one-cycle result/result_valid/result_flags pulse and cannot hold it. This block captures those pulses into a small in-order completion queue and retires entries in issue order to the register-file write port (valid/ready).
- Maintains the architectural ALU flags register.

Parameters:
- DATA_WIDTH, 32, result width; matches the execution units.
- NUM_UNITS, 4, number of ALU execution units feeding the block.
- UNIT_ID_WIDTH, 2, width of the unit index; must satisfy 2^UNIT_ID_WIDTH >= NUM_UNITS.
- REG_ADDR_WIDTH, 4, destination register index width.
- DEPTH, 4, completion queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode issues an ALU op this cycle.
- issue_ready  out  1  queue can accept an issue.
- issue_unit  in  UNIT_ID_WIDTH  unit the op was sent to.
- issue_dest  in  REG_ADDR_WIDTH  destination register.
- issue_flags_we  in  1  op updates the flags register.
- unit_result_valid  in  NUM_UNITS  per-unit result pulse.
- unit_result  in  NUM_UNITS*DATA_WIDTH  unit u occupies bits [u*DATA_WIDTH +: DATA_WIDTH].
- unit_result_flags  in  NUM_UNITS*4  unit u occupies [u*4 +: 4]; bit0 zero, bit1 neg, bit2 over, bit3 carry.
- wb_valid  out  1  writeback data valid.
- wb_ready  in  1  register file accepts writeback.
- wb_data  out  DATA_WIDTH  writeback value.
- wb_dest  out  REG_ADDR_WIDTH  writeback register.
- flags_out  out  4  architectural flags register.
- pending  out  1  queue non-empty or wb_valid high.

Behaviour:
- Reset (synchronous, active-high; overrides everything in the same cycle):
  - Head/tail pointers and count go to 0; all entry done bits clear.
  - wb_valid=0, wb_data=0, wb_dest=0, flags_out=4'h0.
  - issue_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all pending entries and any held writeback.
- Queue entry fields: unit, dest, flags_we, done, data, flags.
- Issue:
  - issue_ready = (count != DEPTH), derived from registered count only.
  - A slot freed by retirement becomes available the following cycle; there is no same-cycle reuse.
  - On issue_valid && issue_ready: write the entry at tail with done=0, then advance tail.
  - issue_valid while !issue_ready is ignored.
- Capture:
  - For each unit u with unit_result_valid[u]=1, the oldest valid entry with unit==u and done==0 gets data, flags and done=1 at the clock edge.
  - Entries allocated in the same cycle are not eligible; units have >=1 cycle latency.
  - Several units may complete in the same cycle. Each targets its own entry, all are captured, and no result is lost.
  - A result with no matching pending entry (orphan) is dropped.
- Retire:
  - Retire when the head entry's done=1 and (wb_valid==0 || wb_ready==1).
  - On retire: wb_data/wb_dest load from the head, wb_valid goes to 1, and head advances.
  - If the retired entry's flags_we=1, flags_out loads the entry's flags on the same edge.
  - If wb_valid && wb_ready and nothing retires, wb_valid goes to 0.
  - wb_data and wb_dest stay stable while wb_valid && !wb_ready.
- Latency: a unit pulse in cycle N at the head with the output free gives wb_valid=1 in cycle N+1. This is 1 cycle, giving a sustained throughput of 1 op/cycle.
- Count: count += issue - retire, so a simultaneous issue and retire leaves count unchanged. Pointers wrap modulo DEPTH.
- Ordering: retirement is strictly in issue order even when a younger entry completes first.
- pending = (count != 0) || wb_valid.

Optional Feature:
- Macro: W0RM_ALU_WB_ORPHAN_CHECK_EN.
- Defined:
  - Adds output port err_orphan (1 bit, sticky; reset 0).
  - err_orphan is set on the edge following any orphan result pulse and is cleared only by reset.
- Undefined: port absent; orphans are silently dropped. All other behaviour is identical.

Test Plan:
- Issue unit1/dest3/flags_we=1, then unit1 result 0xFFFFFF80 with flags 4'b0010 two cycles later, wb_ready=1 -> next cycle wb_valid=1, wb_data=0xFFFFFF80, wb_dest=3, flags_out=4'b0010; pending drops after one cycle.
- Issue A (unit0, dest1) then B (unit2, dest2); unit2 returns 0x22 before unit0 returns 0x11 -> writeback order dest1=0x11 then dest2=0x22, and B never precedes A.
- Issue 4 ops with no results -> issue_ready=0 and a 5th issue_valid is ignored. Then complete the head with wb_ready=1 -> issue_ready returns 1 the cycle after retire.
- Hold wb_ready=0 with wb_valid=1 and head done -> wb_data/wb_dest stable, no retire. Raise wb_ready -> the next entry presents on the following cycle.
- Units 0 and 3 pulse in the same cycle for entries 0 and 1, with flags_we=0 on both -> both retire on consecutive cycles and flags_out is unchanged.
- Reset asserted with 3 pending entries and wb_valid=1 -> the next cycle has wb_valid=0, flags_out=0, pending=0, issue_ready=1. With W0RM_ALU_WB_ORPHAN_CHECK_EN, a unit1 pulse after reset sets err_orphan=1.
